// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared forwarding encodings, MDU state encoding and forward-select helper
package hazard_pkg;

  localparam logic [1:0] FW_NONE = 2'b00;
  localparam logic [1:0] FW_WB   = 2'b01;
  localparam logic [1:0] FW_MEM  = 2'b10;

  localparam int MDU_CNT_W = 6;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_t;

  // Younger producer (M) wins over older (W); register 0 is never forwarded.
  function automatic logic [1:0] fw_select(
    input logic       wr_m,
    input logic [4:0] addr_m,
    input logic       wr_w,
    input logic [4:0] addr_w,
    input logic [4:0] src
  );
    logic [1:0] sel;
    sel = FW_NONE;
    if (wr_m && (addr_m != 5'd0) && (addr_m == src))
      sel = FW_MEM;
    else if (wr_w && (addr_w != 5'd0) && (addr_w == src))
      sel = FW_WB;
    return sel;
  endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - multi-cycle MULT/DIV sequencer producing registered busy/done
module mdu_sequencer #(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic op,
  output logic busy,
  output logic done
);
  import hazard_pkg::*;

  localparam logic [MDU_CNT_W-1:0] MUL_LOAD = MDU_CNT_W'(MUL_LATENCY - 1);
  localparam logic [MDU_CNT_W-1:0] DIV_LOAD = MDU_CNT_W'(DIV_LATENCY - 1);

  mdu_state_t           state;
  logic [MDU_CNT_W-1:0] cnt;
  logic [MDU_CNT_W-1:0] load_val;

  assign load_val = op ? DIV_LOAD : MUL_LOAD;

  // busy/done are registered alongside the state so they track it exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MDU_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        MDU_IDLE: begin
          done <= 1'b0;
          if (start) begin
            cnt   <= load_val;
            state <= MDU_BUSY;
            busy  <= 1'b1;
          end
        end
        MDU_BUSY: begin
          if (cnt == '0) begin
            state <= MDU_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        MDU_DONE: begin
          done <= 1'b0;
          if (start) begin
            cnt   <= load_val;
            state <= MDU_BUSY;
            busy  <= 1'b1;
          end else begin
            state <= MDU_IDLE;
          end
        end
        default: begin
          state <= MDU_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - forwarding, load-use/MDU stall and branch flush control; MDU under HAZARD_MDU_EN
module hazard_controller #(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_addrD,
  input  logic [4:0] rt_addrD,
  input  logic [4:0] rs_addrE,
  input  logic [4:0] rt_addrE,
  input  logic [4:0] write_reg_addrE,
  input  logic [4:0] write_reg_addrM,
  input  logic [4:0] write_reg_addrW,
  input  logic       reg_writeE,
  input  logic       reg_writeM,
  input  logic       reg_writeW,
  input  logic       mem_to_regE,
  input  logic       branch_takenE,
  input  logic       md_startE,
  input  logic       md_opE,
  input  logic       md_startD,
  input  logic       md_readD,
  output logic [1:0] fw_alu1,
  output logic [1:0] fw_alu2,
  output logic       stallF,
  output logic       stallD,
  output logic       flushD,
  output logic       flushE,
  output logic       md_busy,
  output logic       md_done
);
  import hazard_pkg::*;

  logic lu;
  logic ms;
  logic hold;

  assign fw_alu1 = fw_select(reg_writeM, write_reg_addrM, reg_writeW, write_reg_addrW, rs_addrE);
  assign fw_alu2 = fw_select(reg_writeM, write_reg_addrM, reg_writeW, write_reg_addrW, rt_addrE);

  assign lu = mem_to_regE & reg_writeE & (write_reg_addrE != 5'd0) &
              ((write_reg_addrE == rs_addrD) | (write_reg_addrE == rt_addrD));

`ifdef HAZARD_MDU_EN
  mdu_sequencer #(
    .MUL_LATENCY(MUL_LATENCY),
    .DIV_LATENCY(DIV_LATENCY)
  ) u_mdu_sequencer (
    .clk  (clk),
    .rst  (rst),
    .start(md_startE),
    .op   (md_opE),
    .busy (md_busy),
    .done (md_done)
  );

  assign ms = (md_readD | md_startD) & (md_busy | md_startE);
`else
  logic unused_md_inputs;
  localparam int unused_latency_sum = MUL_LATENCY + DIV_LATENCY;

  assign unused_md_inputs = ^{clk, rst, md_startE, md_opE, md_startD, md_readD};
  assign md_busy = 1'b0;
  assign md_done = 1'b0;
  assign ms      = 1'b0;
`endif

  // A taken branch squashes the stalled D instruction anyway, so it releases the stall.
  assign hold   = (lu | ms) & ~branch_takenE;
  assign stallF = hold;
  assign stallD = hold;
  assign flushE = branch_takenE | lu | ms;
  assign flushD = branch_takenE;

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - self-checking bench for hazard_controller with a timeline-based MDU reference
module tb_hazard_controller;

  localparam int MUL_L = 4;
  localparam int DIV_L = 32;
`ifdef HAZARD_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs_addrD = '0, rt_addrD = '0, rs_addrE = '0, rt_addrE = '0;
  logic [4:0] write_reg_addrE = '0, write_reg_addrM = '0, write_reg_addrW = '0;
  logic       reg_writeE = 0, reg_writeM = 0, reg_writeW = 0;
  logic       mem_to_regE = 0, branch_takenE = 0;
  logic       md_startE = 0, md_opE = 0, md_startD = 0, md_readD = 0;
  logic [1:0] fw_alu1, fw_alu2;
  logic       stallF, stallD, flushD, flushE, md_busy, md_done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int s_start = -1000;
  int s_lat = MUL_L;

  hazard_controller #(.MUL_LATENCY(MUL_L), .DIV_LATENCY(DIV_L)) dut (
    .clk(clk), .rst(rst),
    .rs_addrD(rs_addrD), .rt_addrD(rt_addrD), .rs_addrE(rs_addrE), .rt_addrE(rt_addrE),
    .write_reg_addrE(write_reg_addrE), .write_reg_addrM(write_reg_addrM), .write_reg_addrW(write_reg_addrW),
    .reg_writeE(reg_writeE), .reg_writeM(reg_writeM), .reg_writeW(reg_writeW),
    .mem_to_regE(mem_to_regE), .branch_takenE(branch_takenE),
    .md_startE(md_startE), .md_opE(md_opE), .md_startD(md_startD), .md_readD(md_readD),
    .fw_alu1(fw_alu1), .fw_alu2(fw_alu2), .stallF(stallF), .stallD(stallD),
    .flushD(flushD), .flushE(flushE), .md_busy(md_busy), .md_done(md_done)
  );

  always #5 clk = ~clk;

  // Reference: an accepted start at cycle s gives busy in s+1..s+L and done at s+L+1.
  function automatic bit exp_busy();
    return MDU_EN && (cyc >= s_start + 1) && (cyc <= s_start + s_lat);
  endfunction

  function automatic bit exp_done();
    return MDU_EN && (cyc == s_start + s_lat + 1);
  endfunction

  function automatic logic [1:0] exp_fw(input logic [4:0] src);
    if (reg_writeM && write_reg_addrM != 0 && write_reg_addrM == src) return 2'b10;
    if (reg_writeW && write_reg_addrW != 0 && write_reg_addrW == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic tick();
    if (!rst && md_startE && !exp_busy()) begin
      s_start = cyc;
      s_lat = md_opE ? DIV_L : MUL_L;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_inputs();
    {rs_addrD, rt_addrD, rs_addrE, rt_addrE} = '0;
    {write_reg_addrE, write_reg_addrM, write_reg_addrW} = '0;
    {reg_writeE, reg_writeM, reg_writeW, mem_to_regE, branch_takenE} = '0;
    {md_startE, md_opE, md_startD, md_readD} = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    #2;
    n_cmp++; if (md_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", md_busy); end
    n_cmp++; if (md_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", md_done); end
    n_cmp++; if ({stallF, stallD, flushD, flushE} !== 4'b0) begin n_bad++; $display("FAIL reset_ctl: got %b want 0000", {stallF, stallD, flushD, flushE}); end
    @(posedge clk); #1;
    rst = 1'b0;
    s_start = -1000;
    cyc = 0;
    tick();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    write_reg_addrM = 8; reg_writeM = 1; write_reg_addrW = 8; reg_writeW = 1; rs_addrE = 8; rt_addrE = 3;
    #1;
    n_cmp++; if (fw_alu1 !== 2'b10) begin n_bad++; $display("FAIL fw1_mem: got %b want 10", fw_alu1); end
    n_cmp++; if (fw_alu2 !== 2'b00) begin n_bad++; $display("FAIL fw2_none: got %b want 00", fw_alu2); end
    reg_writeM = 0; rt_addrE = 8;
    #1;
    n_cmp++; if (fw_alu1 !== 2'b01) begin n_bad++; $display("FAIL fw1_wb: got %b want 01", fw_alu1); end
    n_cmp++; if (fw_alu2 !== 2'b01) begin n_bad++; $display("FAIL fw2_wb: got %b want 01", fw_alu2); end
    reg_writeM = 1; write_reg_addrM = 0; write_reg_addrW = 0; rs_addrE = 0; rt_addrE = 0;
    #1;
    n_cmp++; if ({fw_alu1, fw_alu2} !== 4'b0000) begin n_bad++; $display("FAIL fw_zero: got %b want 0000", {fw_alu1, fw_alu2}); end
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    mem_to_regE = 1; reg_writeE = 1; write_reg_addrE = 9; rt_addrD = 9; rs_addrD = 2;
    #1;
    n_cmp++; if ({stallF, stallD, flushE, flushD} !== 4'b1110) begin n_bad++; $display("FAIL lu_stall: got %b want 1110", {stallF, stallD, flushE, flushD}); end
    tick();
    mem_to_regE = 0; reg_writeE = 0; write_reg_addrE = 0;
    #1;
    n_cmp++; if ({stallF, stallD, flushE, flushD} !== 4'b0000) begin n_bad++; $display("FAIL lu_release: got %b want 0000", {stallF, stallD, flushE, flushD}); end
    tick();
  endtask

  task automatic test_branch_over_stall();
    clear_inputs();
    mem_to_regE = 1; reg_writeE = 1; write_reg_addrE = 9; rs_addrD = 9; branch_takenE = 1;
    #1;
    n_cmp++; if ({stallF, stallD, flushD, flushE} !== 4'b0011) begin n_bad++; $display("FAIL br_over_lu: got %b want 0011", {stallF, stallD, flushD, flushE}); end
    tick();
    clear_inputs();
  endtask

  task automatic test_mdu_mult();
`ifdef HAZARD_MDU_EN
    clear_inputs();
    md_startE = 1; md_opE = 0; md_readD = 1;
    #1;
    n_cmp++; if (stallD !== 1'b1) begin n_bad++; $display("FAIL mult_stall_t0: got %b want 1", stallD); end
    tick();
    md_startE = 0;
    for (int k = 1; k <= MUL_L + 2; k++) begin
      #1;
      n_cmp++; if (md_busy !== (k <= MUL_L)) begin n_bad++; $display("FAIL mult_busy k=%0d: got %b want %b", k, md_busy, k <= MUL_L); end
      n_cmp++; if (md_done !== (k == MUL_L + 1)) begin n_bad++; $display("FAIL mult_done k=%0d: got %b want %b", k, md_done, k == MUL_L + 1); end
      n_cmp++; if (stallD !== (k <= MUL_L)) begin n_bad++; $display("FAIL mult_stall k=%0d: got %b want %b", k, stallD, k <= MUL_L); end
      tick();
    end
    clear_inputs();
`else
    clear_inputs();
    md_startE = 1; md_readD = 1; md_startD = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if ({md_busy, md_done, stallD, flushE} !== 4'b0) begin n_bad++; $display("FAIL mdu_off k=%0d: got %b want 0000", k, {md_busy, md_done, stallD, flushE}); end
      tick();
    end
    clear_inputs();
`endif
  endtask

  task automatic test_mdu_reset();
`ifdef HAZARD_MDU_EN
    clear_inputs();
    md_startE = 1; md_opE = 1;
    tick();
    md_startE = 0;
    for (int k = 1; k < 5; k++) tick();
    rst = 1;
    s_start = -1000;
    #1;
    n_cmp++; if ({md_busy, md_done} !== 2'b00) begin n_bad++; $display("FAIL rst_async: got %b want 00", {md_busy, md_done}); end
    tick();
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if ({md_busy, md_done} !== 2'b00) begin n_bad++; $display("FAIL rst_hold k=%0d: got %b want 00", k, {md_busy, md_done}); end
      tick();
    end
    md_startE = 1; md_opE = 0;
    tick();
    md_startE = 0;
    for (int k = 1; k <= MUL_L + 1; k++) begin
      #1;
      n_cmp++; if ({md_busy, md_done} !== {k <= MUL_L, k == MUL_L + 1}) begin n_bad++; $display("FAIL rst_remult k=%0d: got %b want %b", k, {md_busy, md_done}, {k <= MUL_L, k == MUL_L + 1}); end
      tick();
    end
    tick();
`endif
  endtask

  task automatic test_back_to_back();
`ifdef HAZARD_MDU_EN
    clear_inputs();
    md_startE = 1;
    tick();
    md_startE = 0;
    for (int k = 1; k <= MUL_L; k++) tick();
    md_startE = 1;
    #1;
    n_cmp++; if (md_done !== 1'b1) begin n_bad++; $display("FAIL b2b_done: got %b want 1", md_done); end
    tick();
    md_startE = 0;
    #1;
    n_cmp++; if ({md_busy, md_done} !== 2'b10) begin n_bad++; $display("FAIL b2b_rebusy: got %b want 10", {md_busy, md_done}); end
    for (int k = 1; k <= MUL_L + 1; k++) tick();
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rs_addrD = 5'($urandom_range(0, 3)); rt_addrD = 5'($urandom_range(0, 3));
      rs_addrE = 5'($urandom_range(0, 3)); rt_addrE = 5'($urandom_range(0, 3));
      write_reg_addrE = 5'($urandom_range(0, 3)); write_reg_addrM = 5'($urandom_range(0, 3));
      write_reg_addrW = 5'($urandom_range(0, 3));
      reg_writeE = 1'($urandom); reg_writeM = 1'($urandom); reg_writeW = 1'($urandom);
      mem_to_regE = 1'($urandom); branch_takenE = ($urandom_range(0, 7) == 0);
      md_startE = ($urandom_range(0, 5) == 0); md_opE = ($urandom_range(0, 3) == 0);
      md_startD = ($urandom_range(0, 3) == 0); md_readD = ($urandom_range(0, 2) == 0);
      #1;
      begin
        bit lu_e, ms_e, hold_e;
        lu_e = mem_to_regE && reg_writeE && write_reg_addrE != 0 &&
               (write_reg_addrE == rs_addrD || write_reg_addrE == rt_addrD);
        ms_e = MDU_EN && (md_readD || md_startD) && (exp_busy() || md_startE);
        hold_e = (lu_e || ms_e) && !branch_takenE;
        n_cmp++; if (fw_alu1 !== exp_fw(rs_addrE)) begin n_bad++; $display("FAIL rnd_fw1 i=%0d: got %b want %b", i, fw_alu1, exp_fw(rs_addrE)); end
        n_cmp++; if (fw_alu2 !== exp_fw(rt_addrE)) begin n_bad++; $display("FAIL rnd_fw2 i=%0d: got %b want %b", i, fw_alu2, exp_fw(rt_addrE)); end
        n_cmp++; if ({stallF, stallD} !== {hold_e, hold_e}) begin n_bad++; $display("FAIL rnd_stall i=%0d: got %b want %b", i, {stallF, stallD}, {hold_e, hold_e}); end
        n_cmp++; if (flushD !== branch_takenE) begin n_bad++; $display("FAIL rnd_flushD i=%0d: got %b want %b", i, flushD, branch_takenE); end
        n_cmp++; if (flushE !== (branch_takenE || lu_e || ms_e)) begin n_bad++; $display("FAIL rnd_flushE i=%0d: got %b want %b", i, flushE, branch_takenE || lu_e || ms_e); end
        n_cmp++; if (md_busy !== exp_busy()) begin n_bad++; $display("FAIL rnd_busy i=%0d: got %b want %b", i, md_busy, exp_busy()); end
        n_cmp++; if (md_done !== exp_done()) begin n_bad++; $display("FAIL rnd_done i=%0d: got %b want %b", i, md_done, exp_done()); end
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_over_stall();
    test_mdu_mult();
    test_mdu_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
